// File: rtl/avalon_burst_pixel_slave.sv
// avalon_burst_pixel_slave: Avalon-MM burst responder over an on-chip pixel RAM.
// Masked write bursts, fixed-latency read bursts, sticky protocol-error flag.
module avalon_burst_pixel_slave #(
    parameter int DATA_WIDTH        = 32,
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DEPTH_LOG2        = 10,
    parameter int BURST_COUNT_WIDTH = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDRESS_WIDTH-1:0]     s_address,
    input  logic                         s_read,
    input  logic                         s_write,
    input  logic [DATA_WIDTH/8-1:0]      s_byteenable,
    input  logic [DATA_WIDTH-1:0]        s_writedata,
    input  logic [BURST_COUNT_WIDTH-1:0] s_burstcount,
    output logic [DATA_WIDTH-1:0]        s_readdata,
    output logic                         s_readdatavalid,
    output logic                         s_waitrequest,
    output logic                         proto_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BURST,
        READ_BURST
    } state_t;

    state_t                       state;
    logic [DEPTH_LOG2-1:0]        wa;
    logic [DEPTH_LOG2-1:0]        addr_q;
    logic [DEPTH_LOG2-1:0]        ram_wa;
    logic [BURST_COUNT_WIDTH-1:0] left_q;
    logic [BURST_COUNT_WIDTH-1:0] n_in;
    logic                         ram_we;
    logic [DATA_WIDTH-1:0]        ram [DEPTH];
    logic                         unused_addr;

    // Byte offset bits and bits above the RAM depth are dropped; the word
    // index wraps naturally at DEPTH_LOG2 bits.
    assign wa          = s_address[OFF +: DEPTH_LOG2];
    assign unused_addr = ^s_address;
    assign n_in        = (s_burstcount == '0) ?
                         BURST_COUNT_WIDTH'(1) : s_burstcount;

    // Busy whenever in reset or streaming a read burst.
    assign s_waitrequest = !reset || (state == READ_BURST);

    // Writes land in IDLE (beat 0) and WRITE_BURST; held off during reset.
    assign ram_we = reset && s_write &&
                    (state == IDLE || state == WRITE_BURST);
    assign ram_wa = (state == IDLE) ? wa : addr_q;

    // Pixel RAM write port with per-byte enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (s_byteenable[b]) begin
                    ram[ram_wa][b*8 +: 8] <= s_writedata[b*8 +: 8];
                end
            end
        end
    end

    // Burst sequencer, registered read return path and error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            addr_q          <= '0;
            left_q          <= '0;
            s_readdata      <= '0;
            s_readdatavalid <= 1'b0;
            proto_err       <= 1'b0;
        end else begin
            s_readdatavalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s_write) begin
                        addr_q <= wa + 1'b1;
                        left_q <= n_in - 1'b1;
                        if (n_in != BURST_COUNT_WIDTH'(1)) begin
                            state <= WRITE_BURST;
                        end
                        if (s_read) begin
                            proto_err <= 1'b1;
                        end
                    end else if (s_read) begin
                        addr_q <= wa;
                        left_q <= n_in;
                        state  <= READ_BURST;
                    end
                end
                WRITE_BURST: begin
                    if (s_read) begin
                        proto_err <= 1'b1;
                    end
                    if (s_write) begin
                        addr_q <= addr_q + 1'b1;
                        left_q <= left_q - 1'b1;
                        if (left_q == BURST_COUNT_WIDTH'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                READ_BURST: begin
                    if (left_q != '0) begin
                        s_readdata      <= ram[addr_q];
                        s_readdatavalid <= 1'b1;
                        addr_q          <= addr_q + 1'b1;
                        left_q          <= left_q - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_burst_pixel_slave.sv
// tb_avalon_burst_pixel_slave: directed and random bursts checked against
// a word-array memory model and a cycle-stamped read-return scoreboard.
module tb_avalon_burst_pixel_slave;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DL    = 10;
    localparam int BCW   = 6;
    localparam int DEPTH = 1 << DL;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [AW-1:0]  s_address = '0;
    logic           s_read = 1'b0;
    logic           s_write = 1'b0;
    logic [3:0]     s_byteenable = '0;
    logic [DW-1:0]  s_writedata = '0;
    logic [BCW-1:0] s_burstcount = '0;
    logic [DW-1:0]  s_readdata;
    logic           s_readdatavalid;
    logic           s_waitrequest;
    logic           proto_err;

    avalon_burst_pixel_slave #(
        .DATA_WIDTH(DW),
        .ADDRESS_WIDTH(AW),
        .DEPTH_LOG2(DL),
        .BURST_COUNT_WIDTH(BCW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_address(s_address),
        .s_read(s_read),
        .s_write(s_write),
        .s_byteenable(s_byteenable),
        .s_writedata(s_writedata),
        .s_burstcount(s_burstcount),
        .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .s_waitrequest(s_waitrequest),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] wdat [64];
    logic [3:0]  wbe [64];
    logic [31:0] lit [$];

    typedef struct {
        int          due;
        logic [31:0] d;
    } exp_t;
    exp_t rq [$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    // Read-return monitor: each expected beat must show up on its cycle.
    always @(negedge clk) begin
        if (rq.size() > 0 && rq[0].due == cyc) begin
            check("rdv", s_readdatavalid, 1);
            check("rdata", s_readdata, rq[0].d);
            void'(rq.pop_front());
        end else if (s_readdatavalid) begin
            check("rdv_idle", s_readdatavalid, 0);
        end
    end

    task automatic do_write(input int wa, input int nraw, input int stall_at,
                            input int stall_len, input bit rstall,
                            input bit rd_mid);
        int n;
        int i;
        int st;
        n = (nraw == 0) ? 1 : nraw;
        i = 0;
        st = 0;
        while (i < n) begin
            @(negedge clk);
            if ((i == stall_at && st < stall_len) ||
                (rstall && i > 0 && $urandom_range(0, 3) == 0)) begin
                if (i == stall_at) st++;
                s_write = 1'b0;
                s_read = 1'b0;
                s_address = $urandom;
                s_writedata = $urandom;
            end else begin
                s_write = 1'b1;
                s_read = rd_mid && (i == 1);
                s_address = (i == 0) ? ((wa << 2) | $urandom_range(0, 3))
                                     : $urandom;
                s_burstcount = (i == 0) ? BCW'(nraw) : BCW'($urandom);
                s_writedata = wdat[i];
                s_byteenable = wbe[i];
                if (i == 0) check("wr_wait", s_waitrequest, 0);
                model[(wa + i) % DEPTH] =
                    merge(model[(wa + i) % DEPTH], wdat[i], wbe[i]);
                i++;
            end
        end
        @(posedge clk);
        #1;
        s_write = 1'b0;
        s_read = 1'b0;
    endtask

    task automatic do_read(input int wa, input int nraw, input bit junk);
        int n;
        int p;
        n = (nraw == 0) ? 1 : nraw;
        @(negedge clk);
        s_address = (wa << 2) | $urandom_range(0, 3);
        s_burstcount = BCW'(nraw);
        s_read = 1'b1;
        s_write = 1'b0;
        check("rd_wait", s_waitrequest, 0);
        @(posedge clk);
        #1;
        p = cyc;
        s_read = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.due = p + 1 + i;
            e.d = (lit.size() > 0) ? lit.pop_front()
                                   : model[(wa + i) % DEPTH];
            rq.push_back(e);
        end
        do begin
            @(negedge clk);
            if (cyc <= p + n) check("rd_busy", s_waitrequest, 1);
            else check("rd_release", s_waitrequest, 0);
            if (junk && cyc < p + n) begin
                s_write = 1'b1;
                s_read = 1'($urandom);
                s_address = $urandom;
                s_writedata = $urandom;
                s_byteenable = 4'hF;
                s_burstcount = BCW'($urandom);
            end else begin
                s_write = 1'b0;
                s_read = 1'b0;
            end
        end while (cyc < p + n + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int p;
        #1 reset = 1'b0;
        #2;
        check("rst_wait0", s_waitrequest, 1);
        check("rst_rdv0", s_readdatavalid, 0);
        check("rst_perr0", proto_err, 0);
        check("rst_rdata0", s_readdata, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_wait", s_waitrequest, 0);

        // Fill words 0..127 so every later read targets known data.
        for (int j = 0; j < 64; j++) begin
            wdat[j] = $urandom;
            wbe[j] = 4'hF;
        end
        do_write(0, 63, -1, 0, 0, 0);
        for (int j = 0; j < 64; j++) wdat[j] = $urandom;
        do_write(63, 63, -1, 0, 1, 0);
        do_write(126, 2, -1, 0, 0, 0);

        // Single write then read-after-write.
        wdat[0] = 32'hDEADBEEF;
        wbe[0] = 4'hF;
        do_write(4, 1, -1, 0, 0, 0);
        lit = '{32'hDEADBEEF};
        do_read(4, 1, 0);

        // 4-beat write with a two-cycle stall, then 4-beat read.
        for (int j = 0; j < 4; j++) wdat[j] = 32'(j + 1);
        do_write(64, 4, 2, 2, 0, 0);
        lit = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_read(64, 4, 0);
        check("perr_burst", proto_err, 0);

        // Byte-enable merge.
        wdat[0] = 32'hFFFFFFFF;
        do_write(128, 1, -1, 0, 0, 0);
        wdat[0] = 32'h12345678;
        wbe[0] = 4'h5;
        do_write(128, 1, -1, 0, 0, 0);
        lit = '{32'hFF34FF78};
        do_read(128, 1, 0);

        // Address wrap across the top of the RAM.
        for (int j = 0; j < 3; j++) begin
            wdat[j] = $urandom;
            wbe[j] = 4'hF;
        end
        do_write(1022, 3, -1, 0, 0, 0);
        lit = '{wdat[2]};
        do_read(0, 1, 0);
        do_read(1022, 3, 0);

        // Random traffic with stalls and ignored requests while busy.
        for (int k = 0; k < 40; k++) begin
            int a;
            int nb;
            a = $urandom_range(0, 120);
            nb = $urandom_range(0, 8);
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 8; j++) begin
                    wdat[j] = $urandom;
                    wbe[j] = 4'($urandom);
                end
                do_write(a, nb, -1, 0, 1, 0);
            end else begin
                do_read(a, nb, 1);
            end
        end
        check("perr_clean", proto_err, 0);

        // Read and write together in IDLE.
        @(negedge clk);
        s_read = 1'b1;
        s_write = 1'b1;
        s_address = 200 << 2;
        s_burstcount = 1;
        s_writedata = 32'hA5A51234;
        s_byteenable = 4'hF;
        model[200] = 32'hA5A51234;
        @(posedge clk);
        #1;
        s_read = 1'b0;
        s_write = 1'b0;
        @(negedge clk);
        check("perr_set", proto_err, 1);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("rw_no_rdv", s_readdatavalid, 0);
        end
        lit = '{32'hA5A51234};
        do_read(200, 1, 0);
        check("perr_sticky", proto_err, 1);

        // Reset during beat 2 of an 8-beat read.
        @(negedge clk);
        s_address = 0;
        s_burstcount = 8;
        s_read = 1'b1;
        @(posedge clk);
        #1;
        p = cyc;
        s_read = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.due = p + 1 + i;
            e.d = model[i];
            rq.push_back(e);
        end
        while (cyc < p + 3) @(negedge clk);
        #1;
        reset = 1'b0;
        rq.delete();
        #1;
        check("rst_rdv", s_readdatavalid, 0);
        check("rst_wait", s_waitrequest, 1);
        repeat (2) @(negedge clk);
        check("rst_perr", proto_err, 0);
        check("rst_rdata", s_readdata, 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_wait", s_waitrequest, 0);
        check("post_rdv", s_readdatavalid, 0);
        do_read(0, 8, 0);
        do_read(4, 1, 0);

        // Read request in the middle of a write burst.
        for (int j = 0; j < 4; j++) begin
            wdat[j] = $urandom;
            wbe[j] = 4'hF;
        end
        do_write(300, 4, -1, 0, 0, 1);
        @(negedge clk);
        check("perr_wb", proto_err, 1);
        do_read(300, 4, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
